// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_pkg : shared codes for the multicycle MIPS control FSM             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mc_pkg;

    localparam logic [3:0] c_ST_FETCH  = 4'd0;
    localparam logic [3:0] c_ST_DECODE = 4'd1;
    localparam logic [3:0] c_ST_MEMADR = 4'd2;
    localparam logic [3:0] c_ST_MEMRD  = 4'd3;
    localparam logic [3:0] c_ST_MEMWB  = 4'd4;
    localparam logic [3:0] c_ST_MEMWR  = 4'd5;
    localparam logic [3:0] c_ST_EXEC   = 4'd6;
    localparam logic [3:0] c_ST_ALUWB  = 4'd7;
    localparam logic [3:0] c_ST_BRANCH = 4'd8;
    localparam logic [3:0] c_ST_ADDIEX = 4'd9;
    localparam logic [3:0] c_ST_ADDIWB = 4'd10;
    localparam logic [3:0] c_ST_JUMP   = 4'd11;
    localparam logic [3:0] c_ST_EXCEPT = 4'd15;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;

    localparam logic [1:0] c_EXC_NONE    = 2'd0;
    localparam logic [1:0] c_EXC_TIMEOUT = 2'd1;
    localparam logic [1:0] c_EXC_ILLEGAL = 2'd2;

    // States that wait on the memory handshake
    function automatic logic is_wait_state(input logic [3:0] st);
        return (st == c_ST_FETCH) || (st == c_ST_MEMRD) || (st == c_ST_MEMWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_wait_timer : memory wait-cycle counter with timeout compare        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mc_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic SYS_reset,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam logic [3:0] c_LIMIT = 4'(TIMEOUT);

    logic [3:0] r_count;

    // Saturates at the limit so a held request can never wrap back to zero
    always_ff @(posedge clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            r_count <= 4'd0;
        end else if (clear) begin
            r_count <= 4'd0;
        end else if (count_en && !expired) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign expired = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_control : multicycle MIPS control FSM with memory-wait timeout     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mc_control
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       SYS_reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       exception,
    output logic [1:0] exc_cause,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [1:0] r_exc_cause;
    logic [1:0] w_next_cause;
    logic       w_expired;
    logic       w_count_en;
    logic       w_clear;

    logic w_pc_write, w_pc_write_cond, w_ir_write, w_reg_write, w_mem_read, w_mem_write;

    assign w_count_en = is_wait_state(r_state) && !mem_ready;
    assign w_clear    = (w_next_state != r_state);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .SYS_reset (SYS_reset),
        .count_en  (w_count_en),
        .clear     (w_clear),
        .expired   (w_expired)
    );

    always_ff @(posedge clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            r_state     <= c_ST_FETCH;
            r_exc_cause <= c_EXC_NONE;
        end else begin
            r_state     <= w_next_state;
            r_exc_cause <= w_next_cause;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_cause    = r_exc_cause;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        iord            = 1'b0;
        mem_to_reg      = 1'b0;
        reg_dst         = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = c_ALU_ADD;
        pc_source       = 2'b00;
        exception       = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = 2'b01;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = c_ST_DECODE;
                end else if (w_expired) begin
                    w_next_state = c_ST_EXCEPT;
                    w_next_cause = c_EXC_TIMEOUT;
                end
            end
            c_ST_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    c_OP_RTYPE:      w_next_state = c_ST_EXEC;
                    c_OP_LW, c_OP_SW: w_next_state = c_ST_MEMADR;
                    c_OP_BEQ:        w_next_state = c_ST_BRANCH;
                    c_OP_ADDI:       w_next_state = c_ST_ADDIEX;
                    c_OP_J:          w_next_state = c_ST_JUMP;
                    default: begin
                        w_next_state = c_ST_EXCEPT;
                        w_next_cause = c_EXC_ILLEGAL;
                    end
                endcase
            end
            c_ST_MEMADR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_next_state = (opcode == c_OP_LW) ? c_ST_MEMRD : c_ST_MEMWR;
            end
            c_ST_MEMRD: begin
                iord       = 1'b1;
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_next_state = c_ST_MEMWB;
                end else if (w_expired) begin
                    w_next_state = c_ST_EXCEPT;
                    w_next_cause = c_EXC_TIMEOUT;
                end
            end
            c_ST_MEMWB: begin
                mem_to_reg   = 1'b1;
                w_reg_write  = 1'b1;
                w_next_state = c_ST_FETCH;
            end
            c_ST_MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_next_state = c_ST_FETCH;
                end else if (w_expired) begin
                    w_next_state = c_ST_EXCEPT;
                    w_next_cause = c_EXC_TIMEOUT;
                end
            end
            c_ST_EXEC: begin
                alu_src_a    = 1'b1;
                alu_op       = c_ALU_FUNCT;
                w_next_state = c_ST_ALUWB;
            end
            c_ST_ALUWB: begin
                reg_dst      = 1'b1;
                w_reg_write  = 1'b1;
                w_next_state = c_ST_FETCH;
            end
            c_ST_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = c_ALU_SUB;
                pc_source       = 2'b01;
                w_pc_write_cond = 1'b1;
                w_next_state    = c_ST_FETCH;
            end
            c_ST_ADDIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_next_state = c_ST_ADDIWB;
            end
            c_ST_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_next_state = c_ST_FETCH;
            end
            c_ST_JUMP: begin
                pc_source    = 2'b10;
                w_pc_write   = 1'b1;
                w_next_state = c_ST_FETCH;
            end
            c_ST_EXCEPT: begin
                exception = 1'b1;
            end
            default: begin
                w_next_state = c_ST_FETCH;
            end
        endcase
    end

    // Reset holds the FSM in FETCH, so the enables are gated to keep mem_read quiet
    assign pc_write      = w_pc_write      & SYS_reset;
    assign pc_write_cond = w_pc_write_cond & SYS_reset;
    assign ir_write      = w_ir_write      & SYS_reset;
    assign reg_write     = w_reg_write     & SYS_reset;
    assign mem_read      = w_mem_read      & SYS_reset;
    assign mem_write     = w_mem_write     & SYS_reset;

    assign exc_cause = r_exc_cause;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_control : directed vector bench for mc_control                  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mc_control;

    logic       clk;
    logic       SYS_reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
    logic       iord, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       exception;
    logic [1:0] exc_cause;
    logic [3:0] state;

    mc_control #(
        .TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .SYS_reset     (SYS_reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .exception     (exception),
        .exc_cause     (exc_cause),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] c_LW = 6'h23, c_SW = 6'h2B, c_RT = 6'h00;
    localparam logic [5:0] c_BEQ = 6'h04, c_J = 6'h02, c_ADDI = 6'h08, c_BAD = 6'h3F;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic [5:0] en;  // {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write}
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    wire [5:0]  w_en  = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write};
    wire [10:0] w_sel = {iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, exception};

    // {iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, exception}
    function automatic logic [10:0] exp_sel(input logic [3:0] st);
        case (st)
            4'd0:    return 11'b0000_01_00_00_0;
            4'd1:    return 11'b0000_11_00_00_0;
            4'd2:    return 11'b0001_10_00_00_0;
            4'd3:    return 11'b1000_00_00_00_0;
            4'd4:    return 11'b0100_00_00_00_0;
            4'd5:    return 11'b1000_00_00_00_0;
            4'd6:    return 11'b0001_00_10_00_0;
            4'd7:    return 11'b0010_00_00_00_0;
            4'd8:    return 11'b0001_00_01_01_0;
            4'd9:    return 11'b0001_10_00_00_0;
            4'd11:   return 11'b0000_00_00_10_0;
            4'd15:   return 11'b0000_00_00_00_1;
            default: return 11'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Called at a falling edge: drive, check, advance to the next falling edge
    task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] st, input logic [5:0] en);
        opcode    = op;
        mem_ready = rdy;
        #1;
        chk("state", 32'(state), 32'(st));
        chk("enables", 32'(w_en), 32'(en));
        chk("selects", 32'(w_sel), 32'(exp_sel(st)));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        SYS_reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_enables", 32'(w_en), 32'd0);
        chk("rst_cause", 32'(exc_cause), 32'd0);
        @(negedge clk);
        SYS_reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int n;
        SYS_reset = 1'b1;
        opcode    = 6'h00;
        mem_ready = 1'b0;

        // lw zero wait, sw zero wait, R-type with 3 fetch waits, beq/j/addi, lw with 2 read waits
        vecs.push_back('{c_LW, 1'b1, 4'd0, 6'b101010});
        vecs.push_back('{c_LW, 1'b1, 4'd1, 6'b000000});
        vecs.push_back('{c_LW, 1'b1, 4'd2, 6'b000000});
        vecs.push_back('{c_LW, 1'b1, 4'd3, 6'b000010});
        vecs.push_back('{c_LW, 1'b1, 4'd4, 6'b000100});
        vecs.push_back('{c_SW, 1'b1, 4'd0, 6'b101010});
        vecs.push_back('{c_SW, 1'b1, 4'd1, 6'b000000});
        vecs.push_back('{c_SW, 1'b1, 4'd2, 6'b000000});
        vecs.push_back('{c_SW, 1'b1, 4'd5, 6'b000001});
        vecs.push_back('{c_RT, 1'b0, 4'd0, 6'b000010});
        vecs.push_back('{c_RT, 1'b0, 4'd0, 6'b000010});
        vecs.push_back('{c_RT, 1'b0, 4'd0, 6'b000010});
        vecs.push_back('{c_RT, 1'b1, 4'd0, 6'b101010});
        vecs.push_back('{c_RT, 1'b1, 4'd1, 6'b000000});
        vecs.push_back('{c_RT, 1'b1, 4'd6, 6'b000000});
        vecs.push_back('{c_RT, 1'b1, 4'd7, 6'b000100});
        vecs.push_back('{c_BEQ, 1'b1, 4'd0, 6'b101010});
        vecs.push_back('{c_BEQ, 1'b1, 4'd1, 6'b000000});
        vecs.push_back('{c_BEQ, 1'b1, 4'd8, 6'b010000});
        vecs.push_back('{c_J, 1'b1, 4'd0, 6'b101010});
        vecs.push_back('{c_J, 1'b1, 4'd1, 6'b000000});
        vecs.push_back('{c_J, 1'b1, 4'd11, 6'b100000});
        vecs.push_back('{c_ADDI, 1'b1, 4'd0, 6'b101010});
        vecs.push_back('{c_ADDI, 1'b1, 4'd1, 6'b000000});
        vecs.push_back('{c_ADDI, 1'b1, 4'd9, 6'b000000});
        vecs.push_back('{c_ADDI, 1'b1, 4'd10, 6'b000100});
        vecs.push_back('{c_LW, 1'b1, 4'd0, 6'b101010});
        vecs.push_back('{c_LW, 1'b1, 4'd1, 6'b000000});
        vecs.push_back('{c_LW, 1'b1, 4'd2, 6'b000000});
        vecs.push_back('{c_LW, 1'b0, 4'd3, 6'b000010});
        vecs.push_back('{c_LW, 1'b0, 4'd3, 6'b000010});
        vecs.push_back('{c_LW, 1'b1, 4'd3, 6'b000010});
        vecs.push_back('{c_LW, 1'b1, 4'd4, 6'b000100});
        vecs.push_back('{c_RT, 1'b0, 4'd0, 6'b000010});

        do_reset();
        foreach (vecs[i]) step(vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].en);

        // Illegal opcode traps and stays trapped
        do_reset();
        step(c_BAD, 1'b1, 4'd0, 6'b101010);
        step(c_BAD, 1'b0, 4'd1, 6'b000000);
        opcode = c_RT;
        #1;
        chk("illegal_state", 32'(state), 32'd15);
        chk("illegal_cause", 32'(exc_cause), 32'd2);
        chk("illegal_sel", 32'(w_sel), 32'(exp_sel(4'd15)));
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            mem_ready = ~mem_ready;
            #1;
            if (state !== 4'd15 || w_en !== 6'd0 || exc_cause !== 2'd2) bad++;
        end
        chk("illegal_hold", 32'(bad), 32'd0);

        // Ready arriving in the cycle the counter reaches TIMEOUT completes the fetch
        do_reset();
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            opcode    = c_RT;
            mem_ready = 1'b0;
            #1;
            if (state !== 4'd0 || w_en !== 6'b000010) bad++;
            @(negedge clk);
        end
        chk("fetch_wait_hold", 32'(bad), 32'd0);
        step(c_RT, 1'b1, 4'd0, 6'b101010);
        step(c_RT, 1'b1, 4'd1, 6'b000000);
        chk("fetch_no_fault_cause", 32'(exc_cause), 32'd0);

        // sw with memory never ready faults after 15 counted waits
        do_reset();
        step(c_SW, 1'b1, 4'd0, 6'b101010);
        step(c_SW, 1'b0, 4'd1, 6'b000000);
        step(c_SW, 1'b0, 4'd2, 6'b000000);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            mem_ready = 1'b0;
            #1;
            if (state !== 4'd5) break;
            n++;
            @(negedge clk);
        end
        chk("memwr_cycles", 32'(n), 32'd16);
        chk("timeout_state", 32'(state), 32'd15);
        chk("timeout_cause", 32'(exc_cause), 32'd1);
        chk("timeout_enables", 32'(w_en), 32'd0);
        chk("timeout_exception", 32'(exception), 32'd1);

        // Reset in the middle of a memory read
        do_reset();
        step(c_LW, 1'b1, 4'd0, 6'b101010);
        step(c_LW, 1'b1, 4'd1, 6'b000000);
        step(c_LW, 1'b1, 4'd2, 6'b000000);
        step(c_LW, 1'b0, 4'd3, 6'b000010);
        #2;
        SYS_reset = 1'b0;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_enables", 32'(w_en), 32'd0);
        @(negedge clk);
        SYS_reset = 1'b1;
        step(c_LW, 1'b1, 4'd0, 6'b101010);
        step(c_LW, 1'b1, 4'd1, 6'b000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum consecutive wait cycles allowed in a memory state before the controller faults.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SYS_reset  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 opcode  input  6  instruction register bits [31:26].
REQ-005 mem_ready  input  1  memory handshake; the access completes in a cycle where mem_ready=1.
REQ-006 pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write  output  1 each  datapath enables.
REQ-007 iord, mem_to_reg, reg_dst, alu_src_a  output  1 each  datapath mux selects.
REQ-008 alu_src_b, alu_op, pc_source  output  2 each  mux selects and ALU operation class.
REQ-009 exception  output  1  fault flag; exc_cause  output  2  cause: 1 = memory timeout, 2 = illegal opcode.
REQ-010 state  output  4  current state code, for the SYS_leds debug mux.

Function
REQ-011 The block SHALL be a multicycle MIPS control FSM with codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, EXCEPT=15.
REQ-012 Every output not listed for a state SHALL be 0 in that state.
REQ-013 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_source=00.
REQ-014 FETCH SHALL hold while mem_ready=0; ir_write=1 and pc_write=1 SHALL be asserted only in the mem_ready=1 cycle, and the next state SHALL be DECODE.
REQ-015 DECODE SHALL drive alu_src_b=11 and branch on opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other->EXCEPT with exc_cause=2.
REQ-016 MEMADR SHALL drive alu_src_a=1 and alu_src_b=10, then go to MEMRD for lw or MEMWR for sw.
REQ-017 MEMRD SHALL drive iord=1 and mem_read=1, hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB SHALL drive mem_to_reg=1 and reg_write=1 with reg_dst=0, then go to FETCH.
REQ-019 MEMWR SHALL drive iord=1 and mem_write=1, hold until mem_ready=1, then go to FETCH.
REQ-020 EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10; ALUWB SHALL drive reg_dst=1 and reg_write=1; both SHALL advance unconditionally.
REQ-021 BRANCH SHALL drive alu_src_a=1, alu_op=01, pc_source=01 and pc_write_cond=1, then go to FETCH.
REQ-022 ADDIEX SHALL drive alu_src_a=1 and alu_src_b=10; ADDIWB SHALL drive reg_write=1; ADDIWB SHALL then go to FETCH.
REQ-023 JUMP SHALL drive pc_source=10 and pc_write=1, then go to FETCH.
REQ-024 With zero-wait memory the latency SHALL be lw 5, sw 4, R-type 4, addi 4, beq 3 and j 3 cycles; each wait cycle SHALL add exactly 1 cycle.
REQ-025 A 4-bit wait counter SHALL increment each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0, and SHALL clear on every state change.
REQ-026 When the wait counter equals TIMEOUT with mem_ready still 0, the next state SHALL be EXCEPT with exc_cause=1; if mem_ready=1 arrives in that same cycle, the access SHALL complete normally.
REQ-027 EXCEPT SHALL drive exception=1 with all enables 0, hold exc_cause, and stay in EXCEPT until reset.

Reset
REQ-028 While SYS_reset=0, state SHALL be FETCH, the wait counter 0 and exc_cause 0, and all enables, including mem_read, SHALL be forced to 0.
REQ-029 Reset asserted mid-instruction SHALL abort immediately with no further enable pulses; the first FETCH access SHALL start on the first rising edge after release.

Structure
REQ-030 State codes, opcode constants, alu_op codes and exc_cause codes SHALL reside in the shared package mc_pkg.
REQ-031 The wait counter and timeout compare SHALL be a single sub-module, mc_wait_timer, with inputs clk, SYS_reset, count_en and clear, and output expired.

Verification
REQ-032 Zero-wait lw (opcode 100011) -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-033 R-type with mem_ready low for 3 cycles in FETCH -> FETCH held for 4 cycles; ir_write pulses exactly once; 7 cycles total.
REQ-034 Opcode 111111 at DECODE -> EXCEPT, exception=1, exc_cause=2; the state holds for 20 further cycles.
REQ-035 sw with mem_ready held low, TIMEOUT=15 -> EXCEPT entered after 15 wait cycles in MEMWR, exc_cause=1, mem_write=0 in EXCEPT.
REQ-036 SYS_reset pulsed low during MEMRD -> outputs 0 at once, state=0, and normal FETCH after release.
REQ-037 beq, then j, then addi back-to-back -> state traces 0,1,8 / 0,1,11 / 0,1,9,10, with pc_write_cond and pc_write each single-cycle.
